// File: rtl/digit_serial_adder.sv
// digit_serial_adder: multi-cycle adder, DIGIT bits per clock through a
// ripple of full-adder cells, with a registered carry between digits.
// Valid/ready handshake on both sides.
// Optional feature macro: SUB_MODE_EN adds the 'sub' port (A - B - cin).
module digit_serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SUB_MODE_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d, acc_sh;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last;

  // Operand B and initial carry as loaded on accept
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
`ifdef SUB_MODE_EN
  assign b_in   = sub ? ~b : b;
  assign cin_in = sub ? ~cin : cin;
`else
  assign b_in   = b;
  assign cin_in = cin;
`endif

  // Operands shift right each digit, so the current digit is always the low slice
  logic [DIGIT-1:0] da, db, ds;
  logic [DIGIT:0]   c;
  assign da   = a_q[DIGIT-1:0];
  assign db   = b_q[DIGIT-1:0];
  assign c[0] = carry_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign ds[i]  = da[i] ^ db[i] ^ c[i];
    assign c[i+1] = (da[i] & db[i]) | (c[i] & (da[i] ^ db[i]));
  end

  // New digit enters at the top; after N digits the register holds the full sum
  assign acc_sh = WIDTH'({ds, acc_q} >> DIGIT);
  assign last   = (cnt_q == CW'(N - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath next-state: capture on accept, one digit per RUN edge
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b_in;
        carry_d = cin_in;
        cnt_d   = '0;
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = c[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        acc_d   = acc_sh;
        if (last) begin
          sum_d  = acc_sh;
          cout_d = c[DIGIT];
          ovf_d  = c[DIGIT] ^ c[DIGIT-1];
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder at WIDTH=8, DIGIT=2 (N=4).
module tb_digit_serial_adder;
  localparam int W = 8;
  localparam int D = 2;
  localparam int N = W / D;
`ifdef SUB_MODE_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, cout, ovf;
  logic [W-1:0] sum;
`ifdef SUB_MODE_EN
  logic         sub = 1'b0;
`endif

  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, acc_cyc = 0;
  res_t exp_q[$];

  digit_serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef SUB_MODE_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", nm, $time);
  endtask

  // Reference: plain integer arithmetic on the effective operands
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb);
    logic [W-1:0] yy;
    logic         cc;
    int           u, s;
    res_t         r;
    yy   = sb ? ~y : y;
    cc   = sb ? ~ci : ci;
    u    = int'(x) + int'(yy) + int'(cc);
    s    = int'($signed(x)) + int'($signed(yy)) + int'(cc);
    r.s  = u[W-1:0];
    r.co = u[W];
    r.ov = (s > 127) || (s < -128);
    return r;
  endfunction

  // Present an operation, wait for acceptance, push the expected result
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci, input logic sb);
    int t = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; a = x; b = y; cin = ci;
`ifdef SUB_MODE_EN
    sub = sb;
`endif
    @(negedge clk);
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (!in_ready) timeout("accept");
    else exp_q.push_back(model(x, y, ci, sb));
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  // Drain the result, optionally with random backpressure
  task automatic wait_result(input bit rnd);
    int t = 0;
    bit done = 1'b0;
    while (!done && t < 200) begin
      @(posedge clk); #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (out_valid && out_ready) done = 1'b1;
      t++;
    end
    if (!done) timeout("result");
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("in_ready_after_xfer", 32'(in_ready), 32'd1);
    chk("out_valid_after_xfer", 32'(out_valid), 32'd0);
  endtask

  // Monitor: pops and compares on each transfer, checks latency and output hold
  logic         prev_ov = 1'b0, prev_rst = 1'b0, prev_co = 1'b0, prev_ovf = 1'b0;
  logic [W-1:0] prev_sum = '0;
  always @(negedge clk) begin
    res_t e;
    if (rst_n && out_valid && !prev_ov) chk("latency", 32'(cyc - acc_cyc), 32'(N));
    if (prev_rst && rst_n && !(out_valid && !prev_ov))
      chk("hold", {23'd0, sum, cout, ovf}, {23'd0, prev_sum, prev_co, prev_ovf});
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_output: got sum %0h with no pending op", sum);
      end else begin
        e = exp_q.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("cout", 32'(cout), 32'(e.co));
        chk("ovf", 32'(ovf), 32'(e.ov));
      end
    end
    prev_ov  = out_valid;
    prev_rst = rst_n;
    prev_sum = sum;
    prev_co  = cout;
    prev_ovf = ovf;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // Reset
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'h00);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Carry ripple across every digit
    send(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_result(1'b0);

    // Signed overflow
    send(8'h7F, 8'h01, 1'b1, 1'b0);
    wait_result(1'b0);

    // Backpressure: result holds, new operands ignored
    send(8'h7F, 8'h01, 1'b1, 1'b0);
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    if (!out_valid) timeout("bp_valid");
    repeat (5) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'(sum), 32'h81);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_in_ready_after", 32'(in_ready), 32'd1);
    repeat (6) begin
      @(negedge clk);
      chk("bp_no_new_op", 32'(out_valid), 32'd0);
    end

    // Reset during the second RUN cycle
    send(8'hAA, 8'h55, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    send(8'h10, 8'h20, 1'b0, 1'b0);
    wait_result(1'b0);

    // Subtraction
    if (HAS_SUB) begin
      send(8'h05, 8'h07, 1'b0, 1'b1);
      wait_result(1'b0);
      send(8'h80, 8'h01, 1'b0, 1'b1);
      wait_result(1'b0);
    end

    // Random operations with random downstream stalls
    for (int i = 0; i < 40; i++) begin
      send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
           HAS_SUB ? 1'($urandom_range(0, 1)) : 1'b0);
      wait_result(1'b1);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
